calc_cmd_parser: RTL and testbench
==================================

Name: calc_cmd_parser

Overview:
- Parametrised, multi-digit successor to the single-digit UART command parser; sits between uart_rx and the calculator ALU.
- Accepts ASCII lines of the form `<op1><operator><op2><terminator>`, where each operand is up to MAX_DIGITS decimal digits.
- Skips spaces, validates the operator set and reports errors.
- Presents both operands as binary values with a one-cycle commit strobe.

Parameters:
- OP_W, 16, width of the binary operand outputs; 10^MAX_DIGITS-1 must be < 2^OP_W (integrator's responsibility).
- MAX_DIGITS, 3, maximum number of digits per operand.
- ALLOW_EQ_TERM, 1, when 1, '=' (0x3D) is also accepted as a terminator; CR/LF are always accepted.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte, qualified by rx_valid.
- rx_valid  input  1  single-cycle strobe per received byte.
- operand1  output  OP_W  binary value of first operand, updated on commit only.
- operand2  output  OP_W  binary value of second operand, updated on commit only.
- operator  output  8  ASCII operator, updated on commit only.
- cmd_valid  output  1  one-cycle pulse: new command committed.
- cmd_err  output  1  one-cycle pulse: line rejected.
- err_code  output  2  cause of last error: 01 illegal char, 10 digit overflow, 11 syntax; held until next error.
- state_debug  output  3  current FSM state encoding.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk. All outputs, both accumulators and digit counters go to 0; the FSM goes to IDLE.
- Reset asserted mid-line discards the partial line and produces no pulse.
- Bytes are processed only in cycles with rx_valid=1. Registered outputs: cmd_valid and cmd_err assert in the cycle after the rx_valid of the deciding byte.
- Byte classes:
  - digit: 0x30-0x39.
  - space: 0x20, ignored in every state except FLUSH.
  - operator: '+' '-' '*' '/' '%'.
  - terminator: 0x0D, 0x0A, or '=' if ALLOW_EQ_TERM.
  - ESC: 0x1B.
  - everything else is illegal.
- FSM states: IDLE=0, OP1=1, OP2_START=2, OP2=3, FLUSH=4.
- IDLE:
  - digit: acc1 = digit, cnt1 = 1, go to OP1.
  - terminator: ignored (empty line).
  - operator: syntax error.
  - illegal: error 01.
- OP1:
  - digit: if cnt1 == MAX_DIGITS, error 10; else acc1 = acc1*10 + digit, cnt1++.
  - operator: latch op_r, go to OP2_START.
  - terminator: error 11.
- OP2_START:
  - digit: acc2 = digit, cnt2 = 1, go to OP2.
  - operator or terminator: error 11.
- OP2:
  - digit: accumulate as in OP1, with the same overflow check.
  - terminator: operand1 <= acc1, operand2 <= acc2, operator <= op_r, pulse cmd_valid, go to IDLE.
  - operator: error 11.
- Illegal byte in OP1, OP2_START or OP2 raises error 01.
- On any error: pulse cmd_err, load err_code, clear accumulators. If the deciding byte was itself a terminator, go to IDLE; else go to FLUSH.
- FLUSH: discard every byte until a terminator, then go to IDLE. No further cmd_err pulses come from the same line.
- ESC in any state: silent abort. Clear accumulators, go to IDLE, no pulse, err_code unchanged.
- Consecutive terminators (CR then LF): the second is seen in IDLE and ignored, so each command yields exactly one cmd_valid.
- Leading zeros count toward MAX_DIGITS.
- The arithmetic width of accumulators is OP_W; no wrap can occur within MAX_DIGITS under the parameter constraint.
- Outputs operand1, operand2 and operator are stable between commits. cmd_valid and cmd_err are never high in the same cycle.
- The block accepts back-to-back rx_valid on consecutive cycles.

Test Plan:
- "12+345\r" with defaults -> one cmd_valid pulse one cycle after CR; operand1=12, operand2=345, operator=0x2B; cmd_err never asserts.
- " 7 * 8 =" with ALLOW_EQ_TERM=1 -> operand1=7, operand2=8, operator=0x2A, single cmd_valid. The same stimulus with ALLOW_EQ_TERM=0 -> err_code=01 on '=', then FLUSH until a following CR.
- "1234+1\r" with MAX_DIGITS=3 -> cmd_err with err_code=10 on the 4th digit; the remaining bytes are flushed; no cmd_valid. A following "9/3\n" commits 9, 3, '/'.
- "5+\r", then "+5\r", then "5+6+\r" -> three cmd_err pulses, each with err_code=11; operand outputs keep their previous committed values.
- "42-" followed by ESC, then "1%2\r\n" -> no pulse on ESC; one cmd_valid with operand1=1, operand2=2, operator=0x25; the trailing LF produces nothing.
- rst_n pulsed low after "99*" with back-to-back rx_valid -> all outputs are 0 immediately. Then "3-1\r" -> operand1=3, operand2=1, cmd_valid.

Source files
------------

// File: rtl/calc_cmd_parser.sv
// calc_cmd_parser: turns an ASCII line "<op1><operator><op2><terminator>" from
// uart_rx into two binary operands plus the operator character for the
// calculator ALU. Multi-digit operands, space skipping and error reporting.
module calc_cmd_parser #(
    parameter int OP_W          = 16,
    parameter int MAX_DIGITS    = 3,
    parameter int ALLOW_EQ_TERM = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic [OP_W-1:0] operand1,
    output logic [OP_W-1:0] operand2,
    output logic [7:0]      operator,
    output logic            cmd_valid,
    output logic            cmd_err,
    output logic [1:0]      err_code,
    output logic [2:0]      state_debug
);

    localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);

    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_SYNTAX   = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        OP1       = 3'd1,
        OP2_START = 3'd2,
        OP2       = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   acc1_q, acc1_d, acc2_q, acc2_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [7:0]        opChar_q, opChar_d;
    logic [OP_W-1:0]   operand1_q, operand1_d, operand2_q, operand2_d;
    logic [7:0]        operator_q, operator_d;
    logic              cmdValid_q, cmdValid_d, cmdErr_q, cmdErr_d;
    logic [1:0]        errCode_q, errCode_d;

    logic              isDigit, isSpace, isOp, isTerm, isEsc;
    logic [OP_W-1:0]   digitVal;
    logic              raiseErr;
    logic [1:0]        errCause;

    // Classify the incoming byte; the low nibble of an ASCII digit is its value.
    always_comb begin
        isDigit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        isSpace  = (rx_data == 8'h20);
        isOp     = (rx_data == 8'h2B) || (rx_data == 8'h2D) || (rx_data == 8'h2A) ||
                   (rx_data == 8'h2F) || (rx_data == 8'h25);
        isTerm   = (rx_data == 8'h0D) || (rx_data == 8'h0A) ||
                   ((ALLOW_EQ_TERM != 0) && (rx_data == 8'h3D));
        isEsc    = (rx_data == 8'h1B);
        digitVal = {{(OP_W-4){1'b0}}, rx_data[3:0]};
    end

    // Parser next-state: one decision per valid byte, errors folded in at the end.
    always_comb begin
        state_d    = state_q;
        acc1_d     = acc1_q;
        acc2_d     = acc2_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        opChar_d   = opChar_q;
        operand1_d = operand1_q;
        operand2_d = operand2_q;
        operator_d = operator_q;
        cmdValid_d = 1'b0;
        cmdErr_d   = 1'b0;
        errCode_d  = errCode_q;
        raiseErr   = 1'b0;
        errCause   = 2'b00;

        if (rx_valid) begin
            if (isEsc) begin
                state_d = IDLE;
                acc1_d  = '0;
                acc2_d  = '0;
                cnt1_d  = '0;
                cnt2_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (isDigit) begin
                            acc1_d  = digitVal;
                            cnt1_d  = CNT_W'(1);
                            state_d = OP1;
                        end else if (isOp) begin
                            raiseErr = 1'b1;
                            errCause = ERR_SYNTAX;
                        end else if (!isTerm && !isSpace) begin
                            raiseErr = 1'b1;
                            errCause = ERR_ILLEGAL;
                        end
                    end
                    OP1: begin
                        if (isDigit) begin
                            if (cnt1_q == CNT_MAX) begin
                                raiseErr = 1'b1;
                                errCause = ERR_OVERFLOW;
                            end else begin
                                acc1_d = (acc1_q << 3) + (acc1_q << 1) + digitVal;
                                cnt1_d = cnt1_q + CNT_W'(1);
                            end
                        end else if (isOp) begin
                            opChar_d = rx_data;
                            state_d  = OP2_START;
                        end else if (isTerm) begin
                            raiseErr = 1'b1;
                            errCause = ERR_SYNTAX;
                        end else if (!isSpace) begin
                            raiseErr = 1'b1;
                            errCause = ERR_ILLEGAL;
                        end
                    end
                    OP2_START: begin
                        if (isDigit) begin
                            acc2_d  = digitVal;
                            cnt2_d  = CNT_W'(1);
                            state_d = OP2;
                        end else if (isOp || isTerm) begin
                            raiseErr = 1'b1;
                            errCause = ERR_SYNTAX;
                        end else if (!isSpace) begin
                            raiseErr = 1'b1;
                            errCause = ERR_ILLEGAL;
                        end
                    end
                    OP2: begin
                        if (isDigit) begin
                            if (cnt2_q == CNT_MAX) begin
                                raiseErr = 1'b1;
                                errCause = ERR_OVERFLOW;
                            end else begin
                                acc2_d = (acc2_q << 3) + (acc2_q << 1) + digitVal;
                                cnt2_d = cnt2_q + CNT_W'(1);
                            end
                        end else if (isTerm) begin
                            operand1_d = acc1_q;
                            operand2_d = acc2_q;
                            operator_d = opChar_q;
                            cmdValid_d = 1'b1;
                            acc1_d     = '0;
                            acc2_d     = '0;
                            cnt1_d     = '0;
                            cnt2_d     = '0;
                            state_d    = IDLE;
                        end else if (isOp) begin
                            raiseErr = 1'b1;
                            errCause = ERR_SYNTAX;
                        end else if (!isSpace) begin
                            raiseErr = 1'b1;
                            errCause = ERR_ILLEGAL;
                        end
                    end
                    FLUSH: begin
                        if (isTerm) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase

                if (raiseErr) begin
                    cmdErr_d  = 1'b1;
                    errCode_d = errCause;
                    acc1_d    = '0;
                    acc2_d    = '0;
                    cnt1_d    = '0;
                    cnt2_d    = '0;
                    state_d   = isTerm ? IDLE : FLUSH;
                end
            end
        end
    end

    // State, accumulators and all registered outputs; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc1_q     <= '0;
            acc2_q     <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            opChar_q   <= '0;
            operand1_q <= '0;
            operand2_q <= '0;
            operator_q <= '0;
            cmdValid_q <= 1'b0;
            cmdErr_q   <= 1'b0;
            errCode_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            opChar_q   <= opChar_d;
            operand1_q <= operand1_d;
            operand2_q <= operand2_d;
            operator_q <= operator_d;
            cmdValid_q <= cmdValid_d;
            cmdErr_q   <= cmdErr_d;
            errCode_q  <= errCode_d;
        end
    end

    assign operand1    = operand1_q;
    assign operand2    = operand2_q;
    assign operator    = operator_q;
    assign cmd_valid   = cmdValid_q;
    assign cmd_err     = cmdErr_q;
    assign err_code    = errCode_q;
    assign state_debug = state_q;

endmodule

// File: tb/tb_calc_cmd_parser.sv
// tb_calc_cmd_parser: directed table-driven bench for calc_cmd_parser.
// dutA uses the default parameters; dutB disables '=' as a terminator.
module tb_calc_cmd_parser;

    // Free-running 100 MHz clock shared by both parsers.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  rxDataA, rxDataB;
    logic        rxValidA, rxValidB;

    logic [15:0] op1A, op2A, op1B, op2B;
    logic [7:0]  operA, operB;
    logic        validA, errA, validB, errB;
    logic [1:0]  codeA, codeB;
    logic [2:0]  stateA, stateB;

    calc_cmd_parser #(.OP_W(16), .MAX_DIGITS(3), .ALLOW_EQ_TERM(1)) dutA (
        .clk(clk), .rst_n(rst_n), .rx_data(rxDataA), .rx_valid(rxValidA),
        .operand1(op1A), .operand2(op2A), .operator(operA),
        .cmd_valid(validA), .cmd_err(errA), .err_code(codeA), .state_debug(stateA)
    );

    calc_cmd_parser #(.OP_W(16), .MAX_DIGITS(3), .ALLOW_EQ_TERM(0)) dutB (
        .clk(clk), .rst_n(rst_n), .rx_data(rxDataB), .rx_valid(rxValidB),
        .operand1(op1B), .operand2(op2B), .operator(operB),
        .cmd_valid(validB), .cmd_err(errB), .err_code(codeB), .state_debug(stateB)
    );

    typedef struct {
        logic [7:0]  data;
        logic        expValid;
        logic        expErr;
        logic [1:0]  expCode;
        logic [15:0] expOp1;
        logic [15:0] expOp2;
        logic [7:0]  expOper;
        logic [2:0]  expState;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   fails  = 0;

    // Append one {byte, expected outputs after that byte} record to the table.
    task automatic addVec(input int d, input int v, input int e, input int c,
                          input int o1, input int o2, input int op, input int st);
        vec_t t;
        t.data     = 8'(d);
        t.expValid = 1'(v);
        t.expErr   = 1'(e);
        t.expCode  = 2'(c);
        t.expOp1   = 16'(o1);
        t.expOp2   = 16'(o2);
        t.expOper  = 8'(op);
        t.expState = 3'(st);
        vecs.push_back(t);
    endtask

    // Single comparison with failure reporting.
    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare every observable output of the selected parser against a record.
    task automatic checkOutput(input vec_t v, input bit useB, input string tag);
        if (!useB) begin
            checkOne({tag, ".cmd_valid"},   32'(validA), 32'(v.expValid));
            checkOne({tag, ".cmd_err"},     32'(errA),   32'(v.expErr));
            checkOne({tag, ".err_code"},    32'(codeA),  32'(v.expCode));
            checkOne({tag, ".operand1"},    32'(op1A),   32'(v.expOp1));
            checkOne({tag, ".operand2"},    32'(op2A),   32'(v.expOp2));
            checkOne({tag, ".operator"},    32'(operA),  32'(v.expOper));
            checkOne({tag, ".state_debug"}, 32'(stateA), 32'(v.expState));
        end else begin
            checkOne({tag, ".cmd_valid"},   32'(validB), 32'(v.expValid));
            checkOne({tag, ".cmd_err"},     32'(errB),   32'(v.expErr));
            checkOne({tag, ".err_code"},    32'(codeB),  32'(v.expCode));
            checkOne({tag, ".operand1"},    32'(op1B),   32'(v.expOp1));
            checkOne({tag, ".operand2"},    32'(op2B),   32'(v.expOp2));
            checkOne({tag, ".operator"},    32'(operB),  32'(v.expOper));
            checkOne({tag, ".state_debug"}, 32'(stateB), 32'(v.expState));
        end
    endtask

    // Drive one byte on the falling edge, then check just after the next rising edge.
    // Consecutive calls keep rx_valid high, so bytes arrive back to back.
    task automatic applyStimulus(input vec_t v, input bit useB, input string tag);
        @(negedge clk);
        if (!useB) begin
            rxDataA  = v.data;
            rxValidA = 1'b1;
            rxValidB = 1'b0;
        end else begin
            rxDataB  = v.data;
            rxValidB = 1'b1;
            rxValidA = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput(v, useB, tag);
    endtask

    // Run one table row list against the chosen parser and empty the table.
    task automatic runTable(input bit useB, input string prefix);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], useB, $sformatf("%s%0d", prefix, i));
        end
        vecs.delete();
    endtask

    // Main test sequence.
    initial begin
        vec_t z;
        z = '{8'h00, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 8'h00, 3'd0};

        rst_n    = 1'b0;
        rxDataA  = 8'h00;
        rxDataB  = 8'h00;
        rxValidA = 1'b0;
        rxValidB = 1'b0;
        #2;
        checkOutput(z, 1'b0, "resetA");
        checkOutput(z, 1'b1, "resetB");
        @(negedge clk);
        rst_n = 1'b1;

        //      data    v  e  code op1  op2  oper   state
        // "12+345\r"
        addVec("1",     0, 0, 0,   0,   0,   0,     1);
        addVec("2",     0, 0, 0,   0,   0,   0,     1);
        addVec("+",     0, 0, 0,   0,   0,   0,     2);
        addVec("3",     0, 0, 0,   0,   0,   0,     3);
        addVec("4",     0, 0, 0,   0,   0,   0,     3);
        addVec("5",     0, 0, 0,   0,   0,   0,     3);
        addVec(8'h0D,   1, 0, 0,   12,  345, 8'h2B, 0);
        // " 7 * 8 ="
        addVec(" ",     0, 0, 0,   12,  345, 8'h2B, 0);
        addVec("7",     0, 0, 0,   12,  345, 8'h2B, 1);
        addVec(" ",     0, 0, 0,   12,  345, 8'h2B, 1);
        addVec("*",     0, 0, 0,   12,  345, 8'h2B, 2);
        addVec(" ",     0, 0, 0,   12,  345, 8'h2B, 2);
        addVec("8",     0, 0, 0,   12,  345, 8'h2B, 3);
        addVec(" ",     0, 0, 0,   12,  345, 8'h2B, 3);
        addVec("=",     1, 0, 0,   7,   8,   8'h2A, 0);
        // "1234+1\r" then "9/3\n"
        addVec("1",     0, 0, 0,   7,   8,   8'h2A, 1);
        addVec("2",     0, 0, 0,   7,   8,   8'h2A, 1);
        addVec("3",     0, 0, 0,   7,   8,   8'h2A, 1);
        addVec("4",     0, 1, 2,   7,   8,   8'h2A, 4);
        addVec("+",     0, 0, 2,   7,   8,   8'h2A, 4);
        addVec("1",     0, 0, 2,   7,   8,   8'h2A, 4);
        addVec(8'h0D,   0, 0, 2,   7,   8,   8'h2A, 0);
        addVec("9",     0, 0, 2,   7,   8,   8'h2A, 1);
        addVec("/",     0, 0, 2,   7,   8,   8'h2A, 2);
        addVec("3",     0, 0, 2,   7,   8,   8'h2A, 3);
        addVec(8'h0A,   1, 0, 2,   9,   3,   8'h2F, 0);
        // "5+\r", "+5\r", "5+6+\r"
        addVec("5",     0, 0, 2,   9,   3,   8'h2F, 1);
        addVec("+",     0, 0, 2,   9,   3,   8'h2F, 2);
        addVec(8'h0D,   0, 1, 3,   9,   3,   8'h2F, 0);
        addVec("+",     0, 1, 3,   9,   3,   8'h2F, 4);
        addVec("5",     0, 0, 3,   9,   3,   8'h2F, 4);
        addVec(8'h0D,   0, 0, 3,   9,   3,   8'h2F, 0);
        addVec("5",     0, 0, 3,   9,   3,   8'h2F, 1);
        addVec("+",     0, 0, 3,   9,   3,   8'h2F, 2);
        addVec("6",     0, 0, 3,   9,   3,   8'h2F, 3);
        addVec("+",     0, 1, 3,   9,   3,   8'h2F, 4);
        addVec(8'h0D,   0, 0, 3,   9,   3,   8'h2F, 0);
        // "42-" ESC, then "1%2\r\n"
        addVec("4",     0, 0, 3,   9,   3,   8'h2F, 1);
        addVec("2",     0, 0, 3,   9,   3,   8'h2F, 1);
        addVec("-",     0, 0, 3,   9,   3,   8'h2F, 2);
        addVec(8'h1B,   0, 0, 3,   9,   3,   8'h2F, 0);
        addVec("1",     0, 0, 3,   9,   3,   8'h2F, 1);
        addVec("%",     0, 0, 3,   9,   3,   8'h2F, 2);
        addVec("2",     0, 0, 3,   9,   3,   8'h2F, 3);
        addVec(8'h0D,   1, 0, 3,   1,   2,   8'h25, 0);
        addVec(8'h0A,   0, 0, 3,   1,   2,   8'h25, 0);
        // "3a\r": illegal character inside the first operand
        addVec("3",     0, 0, 3,   1,   2,   8'h25, 1);
        addVec("a",     0, 1, 1,   1,   2,   8'h25, 4);
        addVec(8'h0D,   0, 0, 1,   1,   2,   8'h25, 0);
        // "999+999\r": both operands at the digit limit
        addVec("9",     0, 0, 1,   1,   2,   8'h25, 1);
        addVec("9",     0, 0, 1,   1,   2,   8'h25, 1);
        addVec("9",     0, 0, 1,   1,   2,   8'h25, 1);
        addVec("+",     0, 0, 1,   1,   2,   8'h25, 2);
        addVec("9",     0, 0, 1,   1,   2,   8'h25, 3);
        addVec("9",     0, 0, 1,   1,   2,   8'h25, 3);
        addVec("9",     0, 0, 1,   1,   2,   8'h25, 3);
        addVec(8'h0D,   1, 0, 1,   999, 999, 8'h2B, 0);
        // "0007+1\r": leading zeros count toward the digit limit
        addVec("0",     0, 0, 1,   999, 999, 8'h2B, 1);
        addVec("0",     0, 0, 1,   999, 999, 8'h2B, 1);
        addVec("0",     0, 0, 1,   999, 999, 8'h2B, 1);
        addVec("7",     0, 1, 2,   999, 999, 8'h2B, 4);
        addVec("+",     0, 0, 2,   999, 999, 8'h2B, 4);
        addVec("1",     0, 0, 2,   999, 999, 8'h2B, 4);
        addVec(8'h0D,   0, 0, 2,   999, 999, 8'h2B, 0);
        // "99*" back to back, then reset mid-line
        addVec("9",     0, 0, 2,   999, 999, 8'h2B, 1);
        addVec("9",     0, 0, 2,   999, 999, 8'h2B, 1);
        addVec("*",     0, 0, 2,   999, 999, 8'h2B, 2);
        runTable(1'b0, "vecA");

        // Asynchronous reset mid-line: outputs clear before any clock edge.
        @(negedge clk);
        rxValidA = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput(z, 1'b0, "midResetA");
        @(negedge clk);
        checkOutput(z, 1'b0, "heldResetA");
        rst_n = 1'b1;

        // "3-1\r" after reset, then one idle cycle to see the pulse drop.
        addVec("3",     0, 0, 0,   0,   0,   0,     1);
        addVec("-",     0, 0, 0,   0,   0,   0,     2);
        addVec("1",     0, 0, 0,   0,   0,   0,     3);
        addVec(8'h0D,   1, 0, 0,   3,   1,   8'h2D, 0);
        runTable(1'b0, "postResetA");
        @(negedge clk);
        rxValidA = 1'b0;
        @(posedge clk);
        #1;
        z = '{8'h00, 1'b0, 1'b0, 2'd0, 16'd3, 16'd1, 8'h2D, 3'd0};
        checkOutput(z, 1'b0, "idleA");

        // " 7 * 8 =\r" with '=' not a terminator: illegal on '=', flushed until CR.
        addVec(" ",     0, 0, 0,   0,   0,   0,     0);
        addVec("7",     0, 0, 0,   0,   0,   0,     1);
        addVec(" ",     0, 0, 0,   0,   0,   0,     1);
        addVec("*",     0, 0, 0,   0,   0,   0,     2);
        addVec(" ",     0, 0, 0,   0,   0,   0,     2);
        addVec("8",     0, 0, 0,   0,   0,   0,     3);
        addVec(" ",     0, 0, 0,   0,   0,   0,     3);
        addVec("=",     0, 1, 1,   0,   0,   0,     4);
        addVec(8'h0D,   0, 0, 1,   0,   0,   0,     0);
        runTable(1'b1, "noEqB");
        @(negedge clk);
        rxValidB = 1'b0;

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
